// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: request handshake, alignment check,
// setup/strobe memory sequence and response/exception return.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_load,
  input  logic [1:0]        req_store,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [ADDR_W-1:0] DAddr,
  output logic [31:0]       DataIn,
  output logic [2:0]        Load,
  output logic [1:0]        Store,
  output logic              mRD,
  output logic              mWR,
  input  logic [31:0]       MemDataOut,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_wr,
  output logic              exc_valid,
  output logic [1:0]        exc_code,
  output logic [ADDR_W-1:0] exc_addr,
  output logic [7:0]        exc_count
);

  typedef enum logic [2:0] {
    IDLE, SETUP, ACCESS, RESP, EXC
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [31:0]       datain_q, datain_d;
  logic [2:0]        load_q, load_d;
  logic [1:0]        store_q, store_d;
  logic              wr_q, wr_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              mrd_q, mrd_d;
  logic              mwr_q, mwr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic              rsp_wr_q, rsp_wr_d;
  logic              exc_valid_q, exc_valid_d;
  logic [1:0]        exc_code_q, exc_code_d;
  logic [ADDR_W-1:0] exc_addr_q, exc_addr_d;
  logic [7:0]        exc_count_q, exc_count_d;

  logic is_half, is_word, mis;

  // Reserved load/store codes fall into the word class.
  always_comb begin
    is_half = 1'b0;
    is_word = 1'b0;
    unique case (1'b1)
      req_wr: begin
        is_half = (req_store == 2'b01);
        is_word = req_store[1];
      end
      default: begin
        is_half = (req_load[2:1] == 2'b01);
        is_word = req_load[2];
      end
    endcase
    mis = (is_half & req_addr[0])
        | (is_word & (|req_addr[1:0]));
  end

  always_comb begin
    state_d     = state_q;
    daddr_d     = daddr_q;
    datain_d    = datain_q;
    load_d      = load_q;
    store_d     = store_q;
    wr_d        = wr_q;
    tag_d       = tag_q;
    mrd_d       = 1'b0;
    mwr_d       = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_wr_d    = rsp_wr_q;
    exc_valid_d = 1'b0;
    exc_code_d  = exc_code_q;
    exc_addr_d  = exc_addr_q;
    exc_count_d = exc_count_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && mis) begin
          state_d     = EXC;
          exc_valid_d = 1'b1;
          exc_code_d  = req_wr ? 2'b10 : 2'b01;
          exc_addr_d  = req_addr;
          if (exc_count_q != 8'hFF)
            exc_count_d = exc_count_q + 8'd1;
        end else if (req_valid) begin
          state_d  = SETUP;
          daddr_d  = req_addr;
          datain_d = req_wdata;
          load_d   = req_load;
          store_d  = req_store;
          wr_d     = req_wr;
          tag_d    = req_tag;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        mrd_d   = ~wr_q;
        mwr_d   = wr_q;
      end
      ACCESS: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = wr_q ? 32'd0 : MemDataOut;
        rsp_tag_d   = tag_q;
        rsp_wr_d    = wr_q;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      EXC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      daddr_q     <= '0;
      datain_q    <= '0;
      load_q      <= '0;
      store_q     <= '0;
      wr_q        <= 1'b0;
      tag_q       <= '0;
      mrd_q       <= 1'b0;
      mwr_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_wr_q    <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= '0;
      exc_addr_q  <= '0;
      exc_count_q <= '0;
    end else begin
      state_q     <= state_d;
      daddr_q     <= daddr_d;
      datain_q    <= datain_d;
      load_q      <= load_d;
      store_q     <= store_d;
      wr_q        <= wr_d;
      tag_q       <= tag_d;
      mrd_q       <= mrd_d;
      mwr_q       <= mwr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_wr_q    <= rsp_wr_d;
      exc_valid_q <= exc_valid_d;
      exc_code_q  <= exc_code_d;
      exc_addr_q  <= exc_addr_d;
      exc_count_q <= exc_count_d;
    end
  end

  // Gated by reset so nothing is accepted while held in reset.
  assign req_ready = (state_q == IDLE) & RST;
  assign DAddr     = daddr_q;
  assign DataIn    = datain_q;
  assign Load      = load_q;
  assign Store     = store_q;
  assign mRD       = mrd_q;
  assign mWR       = mwr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_wr    = rsp_wr_q;
  assign exc_valid = exc_valid_q;
  assign exc_code  = exc_code_q;
  assign exc_addr  = exc_addr_q;
  assign exc_count = exc_count_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-wide
// memory that sign/zero-extends loads itself.
module tb_mem_access_ctrl;

  logic        CLK;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_load;
  logic [1:0]  req_store;
  logic [4:0]  req_tag;
  logic [31:0] DAddr;
  logic [31:0] DataIn;
  logic [2:0]  Load;
  logic [1:0]  Store;
  logic        mRD;
  logic        mWR;
  logic [31:0] MemDataOut;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_tag;
  logic        rsp_wr;
  logic        exc_valid;
  logic [1:0]  exc_code;
  logic [31:0] exc_addr;
  logic [7:0]  exc_count;

  int checks;
  int failures;

  logic [7:0] mem [0:255];

  mem_access_ctrl #(.ADDR_W(32), .TAG_W(5)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_load   (req_load),
    .req_store  (req_store),
    .req_tag    (req_tag),
    .DAddr      (DAddr),
    .DataIn     (DataIn),
    .Load       (Load),
    .Store      (Store),
    .mRD        (mRD),
    .mWR        (mWR),
    .MemDataOut (MemDataOut),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_wr     (rsp_wr),
    .exc_valid  (exc_valid),
    .exc_code   (exc_code),
    .exc_addr   (exc_addr),
    .exc_count  (exc_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  end

  always @(posedge CLK) begin
    if (mWR) begin
      case (Store)
        2'b00: mem[DAddr[7:0]] <= DataIn[7:0];
        2'b01: begin
          mem[DAddr[7:0]]        <= DataIn[7:0];
          mem[DAddr[7:0] + 8'd1] <= DataIn[15:8];
        end
        default: begin
          mem[DAddr[7:0]]        <= DataIn[7:0];
          mem[DAddr[7:0] + 8'd1] <= DataIn[15:8];
          mem[DAddr[7:0] + 8'd2] <= DataIn[23:16];
          mem[DAddr[7:0] + 8'd3] <= DataIn[31:24];
        end
      endcase
    end
  end

  logic [7:0] b0, b1, b2, b3;
  always_comb begin
    b0 = mem[DAddr[7:0]];
    b1 = mem[DAddr[7:0] + 8'd1];
    b2 = mem[DAddr[7:0] + 8'd2];
    b3 = mem[DAddr[7:0] + 8'd3];
    case (Load)
      3'b000:  MemDataOut = {{24{b0[7]}}, b0};
      3'b001:  MemDataOut = {24'd0, b0};
      3'b010:  MemDataOut = {{16{b1[7]}}, b1, b0};
      3'b011:  MemDataOut = {16'd0, b1, b0};
      default: MemDataOut = {b3, b2, b1, b0};
    endcase
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic wr,
                       input logic [31:0] addr,
                       input logic [31:0] wdata,
                       input logic [2:0] ld,
                       input logic [1:0] st,
                       input logic [4:0] tag);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_load  = ld;
    req_store = st;
    req_tag   = tag;
  endtask

  task automatic mem_op(input string nm,
                        input logic wr,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input logic [2:0] ld,
                        input logic [1:0] st,
                        input logic [4:0] tag,
                        input logic [31:0] exp);
    @(negedge CLK);
    check({nm, "_rdy"}, req_ready, 1);
    drive(wr, addr, wdata, ld, st, tag);
    @(negedge CLK);
    req_valid = 1'b0;
    check({nm, "_setup_strb"}, {mRD, mWR}, 0);
    check({nm, "_setup_addr"}, DAddr, addr);
    @(negedge CLK);
    check({nm, "_acc_strb"}, {mRD, mWR},
          wr ? 32'd1 : 32'd2);
    check({nm, "_acc_rv"}, rsp_valid, 0);
    @(negedge CLK);
    check({nm, "_rsp_rv"}, rsp_valid, 1);
    check({nm, "_rsp_strb"}, {mRD, mWR}, 0);
    check({nm, "_rsp_data"}, rsp_data, exp);
    check({nm, "_rsp_tag"}, rsp_tag, tag);
    check({nm, "_rsp_wr"}, rsp_wr, wr);
  endtask

  task automatic exc_op(input string nm,
                        input logic wr,
                        input logic [31:0] addr,
                        input logic [2:0] ld,
                        input logic [1:0] st,
                        input logic [1:0] code);
    @(negedge CLK);
    check({nm, "_rdy"}, req_ready, 1);
    drive(wr, addr, 32'h0, ld, st, 5'd1);
    @(negedge CLK);
    req_valid = 1'b0;
    check({nm, "_ev"}, exc_valid, 1);
    check({nm, "_code"}, exc_code, code);
    check({nm, "_addr"}, exc_addr, addr);
    check({nm, "_strb"}, {mRD, mWR}, 0);
    check({nm, "_rv"}, rsp_valid, 0);
    @(negedge CLK);
    check({nm, "_ev_off"}, exc_valid, 0);
    check({nm, "_rdy2"}, req_ready, 1);
    check({nm, "_strb2"}, {mRD, mWR}, 0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    RST       = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_load  = '0;
    req_store = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;

    #12;
    check("rst_strb", {mRD, mWR}, 0);
    check("rst_rv", rsp_valid, 0);
    check("rst_cnt", exc_count, 0);
    check("rst_daddr", DAddr, 0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("rst_rdy", req_ready, 1);

    mem_op("sw", 1, 32'h10, 32'hDEADBEEF, 3'b100, 2'b10,
           5'd3, 32'h0);
    mem_op("lw", 0, 32'h10, 32'h0, 3'b100, 2'b00,
           5'd7, 32'hDEADBEEF);
    mem_op("lb", 0, 32'h13, 32'h0, 3'b000, 2'b00,
           5'd8, 32'hFFFFFFDE);
    mem_op("lbu", 0, 32'h13, 32'h0, 3'b001, 2'b00,
           5'd9, 32'h000000DE);
    mem_op("lh", 0, 32'h12, 32'h0, 3'b010, 2'b00,
           5'd10, 32'hFFFFDEAD);
    mem_op("lhu", 0, 32'h10, 32'h0, 3'b011, 2'b00,
           5'd11, 32'h0000BEEF);

    exc_op("lw_mis", 0, 32'h12, 3'b100, 2'b00, 2'b01);
    check("cnt1", exc_count, 1);
    exc_op("sh_mis", 1, 32'h21, 3'b000, 2'b01, 2'b10);
    check("cnt2", exc_count, 2);

    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      drive(0, 32'h1, 32'h0, 3'b100, 2'b00, 5'd0);
      @(negedge CLK);
      req_valid = 1'b0;
      @(negedge CLK);
    end
    check("cnt_sat", exc_count, 255);

    @(negedge CLK);
    rsp_ready = 1'b0;
    drive(0, 32'h10, 32'h0, 3'b100, 2'b00, 5'd9);
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      check("bp_rv", rsp_valid, 1);
      check("bp_data", rsp_data, 32'hDEADBEEF);
      check("bp_rdy", req_ready, 0);
      drive(1, 32'h80, 32'h55, 3'b100, 2'b10, 5'd2);
      @(negedge CLK);
    end
    check("bp_tag", rsp_tag, 9);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge CLK);
    check("bp_rv_off", rsp_valid, 0);
    check("bp_idle", req_ready, 1);
    check("bp_daddr", DAddr, 32'h10);
    check("bp_strb", {mRD, mWR}, 0);

    @(negedge CLK);
    drive(1, 32'h40, 32'h11223344, 3'b100, 2'b10, 5'd4);
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    check("ar_mwr", mWR, 1);
    #1;
    RST = 1'b0;
    #1;
    check("ar_mwr_off", mWR, 0);
    check("ar_daddr", DAddr, 0);
    check("ar_din", DataIn, 0);
    check("ar_rv", rsp_valid, 0);
    check("ar_rdy", req_ready, 0);
    check("ar_cnt", exc_count, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("ar_rdy2", req_ready, 1);
    check("ar_rv2", rsp_valid, 0);
    mem_op("lw40", 0, 32'h40, 32'h0, 3'b100, 2'b00,
           5'd12, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
